// File: rtl/mips_bus_pkg.sv
// Shared definitions for the pipeline-to-SRAM-like bus adapters:
// transfer size codes, bridge FSM encoding and byte-enable legality.
package mips_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } bus_state_e;

  // True for byte-enable patterns that map onto a naturally aligned size.
  function automatic logic wen_legal(input logic [3:0] wen);
    logic ok;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      4'b0011, 4'b1100:                   ok = 1'b1;
      4'b1111:                            ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sramlike_bridge_if.sv
// SRAM-like bus between the adapter (master) and the AXI-side bridge (slave).
interface sramlike_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sramlike_bridge_chk.sv
// Run-time checks on the adapter's request stream.
module sramlike_bridge_chk
  import mips_bus_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       req,
  input logic       wr,
  input logic [3:0] wen
);

  // Write requests must carry a byte-enable pattern with a size encoding.
  always @(posedge clk) begin
    if (!rst && req && wr) begin
      assert (wen_legal(wen))
        else $error("sramlike_bridge: unsupported sram_wen pattern %b", wen);
    end
  end

endmodule

// File: rtl/sramlike_bridge_wen_to_size.sv
// Byte-enable to transfer size / low address bits. Reads (wen == 0) and
// unsupported patterns fall back to an aligned word access.
module wen_to_size
  import mips_bus_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  // Decode byte lanes into the narrowest aligned transfer.
  always_comb begin
    size    = SZ_WORD;
    addr_lo = 2'b00;
    case (wen)
      4'b0001: begin size = SZ_BYTE; addr_lo = 2'b00; end
      4'b0010: begin size = SZ_BYTE; addr_lo = 2'b01; end
      4'b0100: begin size = SZ_BYTE; addr_lo = 2'b10; end
      4'b1000: begin size = SZ_BYTE; addr_lo = 2'b11; end
      4'b0011: begin size = SZ_HALF; addr_lo = 2'b00; end
      4'b1100: begin size = SZ_HALF; addr_lo = 2'b10; end
      default: begin size = SZ_WORD; addr_lo = 2'b00; end
    endcase
  end

endmodule

// File: rtl/sramlike_bridge.sv
// Single-cycle SRAM pipeline port to SRAM-like req/addr_ok/data_ok adapter
// with response buffering under external stall and flush draining.
module sramlike_bridge
  import mips_bus_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sram_en,
  input  logic [3:0]    sram_wen,
  input  logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_wdata,
  output logic [DW-1:0] sram_rdata,
  input  logic          ext_stall,
  input  logic          cancel,
  output logic          bus_stall,
  sramlike_bridge_if.master bus
);

  bus_state_e    state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          req_s;
  logic          hit_s;
  logic [3:0]    wen_eff_s;
  logic [1:0]    size_s;
  logic [1:0]    addr_lo_s;

  assign wen_eff_s = (WRITE_EN != 1'b0) ? sram_wen : 4'b0000;
  assign req_s     = sram_en & ~cancel & (state_q == ST_IDLE);
  assign hit_s     = bus.data_ok & ((state_q == ST_RESP) |
                                    ((state_q == ST_IDLE) & bus.addr_ok));

  wen_to_size u_wen_to_size (
    .wen     (wen_eff_s),
    .size    (size_s),
    .addr_lo (addr_lo_s)
  );

  assign bus.size  = size_s;
  assign bus.addr  = {sram_addr[AW-1:2], addr_lo_s};
  assign bus.wdata = sram_wdata;

  // State and held-response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state; the response is latched only when entering DONE.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && bus.addr_ok) begin
          if (bus.data_ok) begin
            if (ext_stall) begin
              state_d = ST_DONE;
              rdata_d = bus.rdata;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (cancel) begin
          state_d = bus.data_ok ? ST_IDLE : ST_DRAIN;
        end else if (bus.data_ok) begin
          if (ext_stall) begin
            state_d = ST_DONE;
            rdata_d = bus.rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_DONE: begin
        if (!ext_stall || cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (bus.data_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs; a post-flush request keeps the stage held until the drain ends.
  always_comb begin
    bus.req    = 1'b0;
    bus.wr     = 1'b0;
    bus_stall  = 1'b0;
    sram_rdata = bus.rdata;
    if (rst) begin
      bus.req   = 1'b0;
      bus.wr    = 1'b0;
      bus_stall = 1'b0;
    end else begin
      bus.req = req_s;
      bus.wr  = |wen_eff_s;
      if (state_q == ST_DRAIN) begin
        bus_stall = sram_en;
      end else begin
        bus_stall = sram_en & ~cancel & (state_q != ST_DONE) & ~hit_s;
      end
    end
    if (state_q == ST_DONE) begin
      sram_rdata = rdata_q;
    end else begin
      sram_rdata = bus.rdata;
    end
  end

  sramlike_bridge_chk u_chk (
    .clk (clk),
    .rst (rst),
    .req (bus.req),
    .wr  (bus.wr),
    .wen (sram_wen)
  );

endmodule

// File: tb/tb_sramlike_bridge.sv
// Self-checking bench for sramlike_bridge: translation table, directed
// corner sequences and randomized accesses against a transaction model.
module tb_sramlike_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        ext_stall;
  logic        cancel;
  logic        bus_stall;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sramlike_bridge_if #(.AW(32), .DW(32)) bus ();

  sramlike_bridge #(.AW(32), .DW(32), .WRITE_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .ext_stall  (ext_stall),
    .cancel     (cancel),
    .bus_stall  (bus_stall),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] a;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] ea;
  } xl_vec_t;

  xl_vec_t xl_tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] a,
                       input logic cn, input logic es, input logic aok,
                       input logic dok, input logic [31:0] rd);
    sram_en      = en;
    sram_wen     = wen;
    sram_addr    = a;
    cancel       = cn;
    ext_stall    = es;
    bus.addr_ok  = aok;
    bus.data_ok  = dok;
    bus.rdata    = rd;
  endtask

  // Expected size/address from the number and position of enabled lanes.
  function automatic void model_xlate(input logic [3:0] wen, input logic [31:0] a,
                                      output logic [1:0] sz, output logic [31:0] ea);
    int n  = 0;
    int lo = 0;
    for (int i = 3; i >= 0; i--) begin
      if (wen[i]) begin
        n++;
        lo = i;
      end
    end
    ea = {a[31:2], 2'b00};
    sz = 2'd2;
    if (n == 1) begin
      sz = 2'd0;
      ea[1:0] = lo[1:0];
    end else if (n == 2) begin
      sz = 2'd1;
      ea[1:0] = lo[1:0];
    end
  endfunction

  // One pipeline access: addr_ok at cycle ad, data_ok at cycle dd (ad <= dd),
  // then the stage is held for 'hold' further cycles by ext_stall.
  task automatic do_access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                           input int ad, input int dd, input int hold, input logic [31:0] rd);
    logic [1:0]  exp_sz;
    logic [31:0] exp_a;
    logic        es;
    model_xlate(wen, a, exp_sz, exp_a);
    sram_wdata = wd;
    for (int c = 0; c <= dd + hold; c++) begin
      es = (c < dd) ? 1'($urandom_range(0, 1)) : (c < dd + hold);
      drive(1'b1, wen, a, 1'b0, es, c == ad, c == dd, (c == dd) ? rd : $urandom);
      #2;
      check("req", 32'(bus.req), 32'(c <= ad));
      check("bus_stall", 32'(bus_stall), 32'(c < dd));
      if (c <= ad) begin
        check("wr", 32'(bus.wr), 32'(wen != 4'b0000));
        check("size", 32'(bus.size), 32'(exp_sz));
        check("addr", bus.addr, exp_a);
        check("wdata", bus.wdata, wd);
      end
      if (c >= dd) check("sram_rdata", sram_rdata, rd);
      next_cycle();
    end
  endtask

  initial begin
    logic [3:0] wen_pool[9];
    wen_pool = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    xl_tab[0] = '{4'b0100, 32'h8000_0003, 1'b1, 2'd0, 32'h8000_0002};
    xl_tab[1] = '{4'b1100, 32'h8000_0003, 1'b1, 2'd1, 32'h8000_0002};
    xl_tab[2] = '{4'b0001, 32'h1000_0007, 1'b1, 2'd0, 32'h1000_0004};
    xl_tab[3] = '{4'b0010, 32'h1000_0004, 1'b1, 2'd0, 32'h1000_0005};
    xl_tab[4] = '{4'b1000, 32'h1000_0004, 1'b1, 2'd0, 32'h1000_0007};
    xl_tab[5] = '{4'b0011, 32'h2000_000A, 1'b1, 2'd1, 32'h2000_0008};
    xl_tab[6] = '{4'b1111, 32'h2000_0013, 1'b1, 2'd2, 32'h2000_0010};
    xl_tab[7] = '{4'b0000, 32'h3000_0006, 1'b0, 2'd2, 32'h3000_0004};

    // Reset: handshake outputs forced low, translation stays combinational.
    rst = 1'b1;
    sram_wdata = 32'h0;
    drive(1'b1, 4'b1111, 32'h0000_0047, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    #2;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_wr", 32'(bus.wr), 32'd0);
    check("rst_bus_stall", 32'(bus_stall), 32'd0);
    check("rst_size", 32'(bus.size), 32'd2);
    check("rst_addr", bus.addr, 32'h0000_0044);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();

    // Translation table: requests held in IDLE with no addr_ok.
    for (int i = 0; i < 8; i++) begin
      sram_wdata = 32'hA5A5_0000 + 32'(i);
      drive(1'b1, xl_tab[i].wen, xl_tab[i].a, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      check("tab_req", 32'(bus.req), 32'd1);
      check("tab_wr", 32'(bus.wr), 32'(xl_tab[i].wr));
      check("tab_size", 32'(bus.size), 32'(xl_tab[i].sz));
      check("tab_addr", bus.addr, xl_tab[i].ea);
      check("tab_wdata", bus.wdata, 32'hA5A5_0000 + 32'(i));
      check("tab_stall", 32'(bus_stall), 32'd1);
      next_cycle();
    end
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();

    // Read with addr_ok at cycle 2, data_ok at cycle 4, then with a 2-cycle hold.
    do_access(4'b0000, 32'h0000_1000, 32'h0, 2, 4, 0, 32'h1234_5678);
    do_access(4'b0000, 32'h0000_1000, 32'h0, 2, 4, 2, 32'h1234_5678);

    // Zero-wait slave, back-to-back reads.
    do_access(4'b0000, 32'h0000_0000, 32'h0, 0, 0, 0, 32'h1111_0000);
    do_access(4'b0000, 32'h0000_0004, 32'h0, 0, 0, 0, 32'h1111_0004);
    do_access(4'b0000, 32'h0000_0008, 32'h0, 0, 0, 0, 32'h1111_0008);

    // Cancel in RESP, new request waits for the drain to finish.
    drive(1'b1, 4'b0000, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2; check("cx_req0", 32'(bus.req), 32'd1);
    next_cycle();
    drive(1'b1, 4'b0000, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2; check("cx_req1", 32'(bus.req), 32'd0); check("cx_stall1", 32'(bus_stall), 32'd0);
    next_cycle();
    for (int c = 2; c <= 4; c++) begin
      drive(1'b1, 4'b0000, 32'hBFC0_0380, 1'b0, 1'b0, 1'b0, c == 4, 32'hDEAD_BEEF);
      #2;
      check("drain_req", 32'(bus.req), 32'd0);
      check("drain_stall", 32'(bus_stall), 32'd1);
      next_cycle();
    end
    drive(1'b1, 4'b0000, 32'hBFC0_0380, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001);
    #2;
    check("post_drain_req", 32'(bus.req), 32'd1);
    check("post_drain_addr", bus.addr, 32'hBFC0_0380);
    check("post_drain_stall", 32'(bus_stall), 32'd0);
    check("post_drain_rdata", sram_rdata, 32'hCAFE_0001);
    next_cycle();

    // Cancel coinciding with data_ok returns straight to IDLE.
    drive(1'b1, 4'b0000, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 4'b0000, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
    #2; check("cxdok_stall", 32'(bus_stall), 32'd0);
    next_cycle();
    drive(1'b1, 4'b0000, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2; check("cxdok_req", 32'(bus.req), 32'd1);
    next_cycle();
    do_access(4'b0000, 32'h0000_0300, 32'h0, 0, 0, 0, 32'h0000_0300);

    // Reset while in RESP.
    drive(1'b1, 4'b1111, 32'h0000_0400, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 4'b1111, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("midrst_req", 32'(bus.req), 32'd0);
    check("midrst_stall", 32'(bus_stall), 32'd0);
    check("midrst_wr", 32'(bus.wr), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("afterrst_req", 32'(bus.req), 32'd0);
    check("afterrst_stall", 32'(bus_stall), 32'd0);
    next_cycle();
    do_access(4'b1111, 32'h0000_0400, 32'h0BAD_F00D, 0, 1, 0, 32'h0);

    // Randomized accesses against the transaction model.
    for (int t = 0; t < 40; t++) begin
      int ad;
      int dd;
      ad = int'($urandom_range(0, 3));
      dd = ad + int'($urandom_range(0, 3));
      do_access(wen_pool[$urandom_range(0, 8)], $urandom, $urandom, ad, dd,
                int'($urandom_range(0, 2)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        #2; check("idle_stall", 32'(bus_stall), 32'd0);
        next_cycle();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
